// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and bus widths for the regfile write-port arbiter.
package rf_wport_arbiter_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int PC_W   = 32;

   localparam int WS_TO_RF_BUS_WD     = 1 + REG_W + DATA_W;
   localparam int ARB_TO_ID_BYPASS_WD = 1 + REG_W + DATA_W;
   localparam int LU_TO_ARB_BUS_WD    = REG_W + DATA_W + PC_W;

   typedef struct packed {
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] data;
      logic [PC_W-1:0]   pc;
   } lu_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_WB,
      SEL_LU
   } wsel_e;

   function automatic logic [WS_TO_RF_BUS_WD-1:0] pack_rf_bus(
      input logic              we,
      input logic [REG_W-1:0]  addr,
      input logic [DATA_W-1:0] data
   );
      return {we, addr, data};
   endfunction

endpackage

// File: rtl/rf_wport_arbiter_lu_hold_buf.sv
// One-entry valid/ready holding buffer for long-latency unit results.
// A capture and a drain may happen in the same cycle; new data wins.
module lu_hold_buf
   import rf_wport_arbiter_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      in_valid,
   input  lu_entry_t in_entry,
   output logic      in_ready,
   input  logic      drain,
   output logic      buf_valid,
   output lu_entry_t buf_entry
);

   logic                        valid_q;
   logic [LU_TO_ARB_BUS_WD-1:0] entry_q;
   logic                        capture;

   assign in_ready  = !valid_q || drain;
   assign capture   = in_valid && in_ready;
   assign buf_valid = valid_q;
   assign buf_entry = lu_entry_t'(entry_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else if (capture) begin
         valid_q <= 1'b1;
         entry_q <= LU_TO_ARB_BUS_WD'(in_entry);
      end else if (drain) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: WB priority, aged LU fallback, registered port.
// Optional trace registers enabled by defining WPORT_TRACE_EN.
module rf_wport_arbiter
   import rf_wport_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wb_valid,
   input  logic                           wb_we,
   input  logic [REG_W-1:0]               wb_dest,
   input  logic [DATA_W-1:0]              wb_data,
   input  logic [PC_W-1:0]                wb_pc,
   output logic                           wb_grant,
   input  logic                           lu_valid,
   input  logic [REG_W-1:0]               lu_dest,
   input  logic [DATA_W-1:0]              lu_data,
   input  logic [PC_W-1:0]                lu_pc,
   output logic                           lu_ready,
   output logic                           rf_we,
   output logic [REG_W-1:0]               rf_waddr,
   output logic [DATA_W-1:0]              rf_wdata,
   output logic                           lu_buf_valid,
   output logic [REG_W-1:0]               lu_buf_dest,
   output logic [ARB_TO_ID_BYPASS_WD-1:0] arb_to_id_bypass,
   output logic [PC_W-1:0]                debug_wb_pc,
   output logic [3:0]                     debug_wb_rf_wen,
   output logic [REG_W-1:0]               debug_wb_rf_wnum,
   output logic [DATA_W-1:0]              debug_wb_rf_wdata
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   lu_entry_t        lu_in;
   lu_entry_t        buf_entry;
   logic             buf_valid;
   logic             wb_wr;
   logic             lu_gnt;
   logic             wb_gnt_port;
   logic [CNT_W-1:0] starve_cnt;
   wsel_e            sel;
   logic [REG_W-1:0] nxt_dest;
   logic [DATA_W-1:0] nxt_data;
   logic [PC_W-1:0]  nxt_pc;

   assign lu_in = '{dest: lu_dest, data: lu_data, pc: lu_pc};

   lu_hold_buf u_buf (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (lu_valid),
      .in_entry  (lu_in),
      .in_ready  (lu_ready),
      .drain     (lu_gnt),
      .buf_valid (buf_valid),
      .buf_entry (buf_entry)
   );

   assign lu_buf_valid = buf_valid;
   assign lu_buf_dest  = buf_entry.dest;

   // The buffered LU write is older, so a same-dest WB write must wait.
   assign wb_wr       = wb_valid && wb_we;
   assign lu_gnt      = buf_valid &&
                        (!wb_wr || starve_cnt == LIMIT ||
                         wb_dest == buf_entry.dest);
   assign wb_gnt_port = wb_wr && !lu_gnt;
   assign wb_grant    = wb_valid && !(wb_wr && lu_gnt);

   always_ff @(posedge clk) begin
      if (reset || lu_gnt || !buf_valid) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_comb begin
      sel      = SEL_NONE;
      nxt_dest = buf_entry.dest;
      nxt_data = buf_entry.data;
      nxt_pc   = buf_entry.pc;
      unique case (1'b1)
         lu_gnt:      sel = SEL_LU;
         wb_gnt_port: begin
            sel      = SEL_WB;
            nxt_dest = wb_dest;
            nxt_data = wb_data;
            nxt_pc   = wb_pc;
         end
         default:     sel = SEL_NONE;
      endcase
   end

   // A write to x0 still consumes the slot but never reaches the file.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (sel != SEL_NONE) begin
         rf_we    <= nxt_dest != '0;
         rf_waddr <= nxt_dest;
         rf_wdata <= nxt_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   assign arb_to_id_bypass = pack_rf_bus(rf_we, rf_waddr, rf_wdata);

`ifdef WPORT_TRACE_EN
   logic [PC_W-1:0] trace_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         trace_pc <= '0;
      end else if (sel != SEL_NONE) begin
         trace_pc <= nxt_pc;
      end
   end

   assign debug_wb_pc       = trace_pc;
   assign debug_wb_rf_wen   = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;
`else
   logic unused_pc;

   assign unused_pc         = ^nxt_pc;
   assign debug_wb_pc       = '0;
   assign debug_wb_rf_wen   = '0;
   assign debug_wb_rf_wnum  = '0;
   assign debug_wb_rf_wdata = '0;
`endif

endmodule
